mem_arbiter: RTL and testbench

- Shares one single-port local memory (18-bit word address, 32-bit data) between three requesters: DMA FSM, CPU and accelerator.
- Sits between those requesters and the memory array. Presents each requester the same En/WrEn/Addr/Data → Out/Valid interface the memory controller exposes.
- Arbitration is round-robin, with exactly one memory transaction in flight at a time.

---
 rtl/mem_arbiter.sv | 252 +++++++++++++++++++++++++
 tb/tb_mem_arbiter.sv | 394 +++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_arbiter.sv
// mem_arbiter
//
// Shares one single-port local memory between three requesters (DMA, CPU,
// accelerator). Requests are arbitrated round-robin and exactly one memory
// transaction is in flight at any time. Each requester sees the same
// En/WrEn/Addr/Data -> Out/Valid handshake that the memory controller offers.
//
// Ports:
//   clk, rst_n                     clock, asynchronous active-low reset
//   DMA*/CPU*/Acl* En, WrEn        request strobe and write select
//   DMA*/CPU*/Acl* Addr, Data      word address and write data
//   DMAOut/CPUOut/AclOut           last read data returned to each requester
//   DMAValid/CPUValid/AclValid     one-cycle completion pulse
//   mem_en, mem_wr_en              memory strobe and write select
//   mem_addr, mem_wdata            memory address and write data
//   mem_rdata                      memory read data, RD_LATENCY cycles after mem_en
//   grant                          one-hot owner of the current transaction
//   busy                           high whenever a transaction is in progress
//
// All outputs come straight from flops.

module mem_arbiter #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 18,
    parameter int RD_LATENCY = 1
) (
    input  logic                  clk,
    input  logic                  rst_n,

    input  logic                  DMAEn,
    input  logic                  DMAWrEn,
    input  logic [ADDR_WIDTH-1:0] DMAAddr,
    input  logic [DATA_WIDTH-1:0] DMAData,
    output logic [DATA_WIDTH-1:0] DMAOut,
    output logic                  DMAValid,

    input  logic                  CPUEn,
    input  logic                  CPUWrEn,
    input  logic [ADDR_WIDTH-1:0] CPUAddr,
    input  logic [DATA_WIDTH-1:0] CPUData,
    output logic [DATA_WIDTH-1:0] CPUOut,
    output logic                  CPUValid,

    input  logic                  AclEn,
    input  logic                  AclWrEn,
    input  logic [ADDR_WIDTH-1:0] AclAddr,
    input  logic [DATA_WIDTH-1:0] AclData,
    output logic [DATA_WIDTH-1:0] AclOut,
    output logic                  AclValid,

    output logic                  mem_en,
    output logic                  mem_wr_en,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    output logic [DATA_WIDTH-1:0] mem_wdata,
    input  logic [DATA_WIDTH-1:0] mem_rdata,

    output logic [2:0]            grant,
    output logic                  busy
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2,
        DONE  = 2'd3
    } state_t;

    // WAIT counts 0 .. RD_LATENCY-1; the last count is the capture cycle.
    localparam logic [1:0] LAST_CNT = 2'(RD_LATENCY - 1);

    state_t                  state_q,     state_d;
    logic [2:0]              last_q,      last_d;
    logic [2:0]              grant_q,     grant_d;
    logic                    busy_q,      busy_d;
    logic [1:0]              cnt_q,       cnt_d;
    logic [2:0]              valid_q,     valid_d;
    logic                    mem_en_q,    mem_en_d;
    logic                    mem_wr_en_q, mem_wr_en_d;
    logic [ADDR_WIDTH-1:0]   mem_addr_q,  mem_addr_d;
    logic [DATA_WIDTH-1:0]   mem_wdata_q, mem_wdata_d;
    logic [DATA_WIDTH-1:0]   out_q [3];
    logic [DATA_WIDTH-1:0]   out_d [3];

    logic [2:0]              req;
    logic [2:0]              win;
    logic                    sel_wr_en;
    logic [ADDR_WIDTH-1:0]   sel_addr;
    logic [DATA_WIDTH-1:0]   sel_wdata;

    assign req = {AclEn, CPUEn, DMAEn};

    // Round-robin pick: search starts at the requester after the last winner,
    // in the fixed ring DMA -> CPU -> Acl -> DMA.
    always_comb begin
        win = 3'b000;
        case (last_q)
            3'b001: begin
                if      (req[1]) win = 3'b010;
                else if (req[2]) win = 3'b100;
                else if (req[0]) win = 3'b001;
            end
            3'b010: begin
                if      (req[2]) win = 3'b100;
                else if (req[0]) win = 3'b001;
                else if (req[1]) win = 3'b010;
            end
            default: begin
                if      (req[0]) win = 3'b001;
                else if (req[1]) win = 3'b010;
                else if (req[2]) win = 3'b100;
            end
        endcase
    end

    // Steer the winner's request fields toward the memory-side registers.
    always_comb begin
        sel_wr_en = DMAWrEn;
        sel_addr  = DMAAddr;
        sel_wdata = DMAData;
        if (win[1]) begin
            sel_wr_en = CPUWrEn;
            sel_addr  = CPUAddr;
            sel_wdata = CPUData;
        end else if (win[2]) begin
            sel_wr_en = AclWrEn;
            sel_addr  = AclAddr;
            sel_wdata = AclData;
        end
    end

    // Next-state and next-output computation. Every output is produced one
    // cycle ahead here so that the registered version lines up with the state
    // it belongs to (e.g. mem_en_d is raised while leaving IDLE, so mem_en is
    // high exactly during ISSUE).
    always_comb begin
        state_d     = state_q;
        last_d      = last_q;
        grant_d     = grant_q;
        busy_d      = busy_q;
        cnt_d       = cnt_q;
        valid_d     = 3'b000;
        mem_en_d    = 1'b0;
        mem_wr_en_d = mem_wr_en_q;
        mem_addr_d  = mem_addr_q;
        mem_wdata_d = mem_wdata_q;
        for (int i = 0; i < 3; i++) begin
            out_d[i] = out_q[i];
        end

        case (state_q)
            IDLE: begin
                if (|req) begin
                    grant_d     = win;
                    last_d      = win;
                    busy_d      = 1'b1;
                    mem_en_d    = 1'b1;
                    mem_wr_en_d = sel_wr_en;
                    mem_addr_d  = sel_addr;
                    mem_wdata_d = sel_wdata;
                    state_d     = ISSUE;
                end else begin
                    grant_d = 3'b000;
                    busy_d  = 1'b0;
                end
            end

            ISSUE: begin
                cnt_d = 2'd0;
                if (mem_wr_en_q) begin
                    valid_d = grant_q;
                    state_d = DONE;
                end else begin
                    state_d = WAIT;
                end
            end

            WAIT: begin
                if (cnt_q == LAST_CNT) begin
                    for (int i = 0; i < 3; i++) begin
                        if (grant_q[i]) begin
                            out_d[i] = mem_rdata;
                        end
                    end
                    valid_d = grant_q;
                    state_d = DONE;
                end else begin
                    cnt_d = cnt_q + 2'd1;
                end
            end

            DONE: begin
                grant_d = 3'b000;
                busy_d  = 1'b0;
                state_d = IDLE;
            end

            default: begin
                grant_d = 3'b000;
                busy_d  = 1'b0;
                state_d = IDLE;
            end
        endcase
    end

    // State and output registers. Reset leaves the last-grant pointer on Acl so
    // that DMA is the first winner afterwards.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            last_q      <= 3'b100;
            grant_q     <= 3'b000;
            busy_q      <= 1'b0;
            cnt_q       <= 2'd0;
            valid_q     <= 3'b000;
            mem_en_q    <= 1'b0;
            mem_wr_en_q <= 1'b0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
            for (int i = 0; i < 3; i++) begin
                out_q[i] <= '0;
            end
        end else begin
            state_q     <= state_d;
            last_q      <= last_d;
            grant_q     <= grant_d;
            busy_q      <= busy_d;
            cnt_q       <= cnt_d;
            valid_q     <= valid_d;
            mem_en_q    <= mem_en_d;
            mem_wr_en_q <= mem_wr_en_d;
            mem_addr_q  <= mem_addr_d;
            mem_wdata_q <= mem_wdata_d;
            for (int i = 0; i < 3; i++) begin
                out_q[i] <= out_d[i];
            end
        end
    end

    assign DMAOut    = out_q[0];
    assign CPUOut    = out_q[1];
    assign AclOut    = out_q[2];
    assign DMAValid  = valid_q[0];
    assign CPUValid  = valid_q[1];
    assign AclValid  = valid_q[2];
    assign mem_en    = mem_en_q;
    assign mem_wr_en = mem_wr_en_q;
    assign mem_addr  = mem_addr_q;
    assign mem_wdata = mem_wdata_q;
    assign grant     = grant_q;
    assign busy      = busy_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// tb_mem_arbiter
//
// Self-checking bench for mem_arbiter. Instance u_dut uses RD_LATENCY=1 and is
// driven by a per-cycle requester engine plus a transaction-level reference
// model. Instance u_l3 uses RD_LATENCY=3 for the max-address read case.

module tb_mem_arbiter;

    localparam int L1 = 1;
    localparam int L2 = 3;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_pass   = 0;
    int n_fail   = 0;
    int cyc      = 0;

    // ---------------- main DUT (RD_LATENCY = 1) ----------------
    logic        r_en   [3];
    logic        r_wr   [3];
    logic [17:0] r_addr [3];
    logic [31:0] r_data [3];
    logic        nxt_en   [3];
    logic        nxt_wr   [3];
    logic [17:0] nxt_addr [3];
    logic [31:0] nxt_data [3];
    logic        nxt_rst = 1'b0;
    bit          r_keep [3];
    bit          r_auto [3];

    logic [31:0] dma_out, cpu_out, acl_out;
    logic        dma_valid, cpu_valid, acl_valid;
    logic        m1_en, m1_wr;
    logic [17:0] m1_addr;
    logic [31:0] m1_wdata, m1_rdata;
    logic [2:0]  grant;
    logic        busy;
    wire  [2:0]  vld = {acl_valid, cpu_valid, dma_valid};

    mem_arbiter #(.DATA_WIDTH(32), .ADDR_WIDTH(18), .RD_LATENCY(L1)) u_dut (
        .clk(clk), .rst_n(rst_n),
        .DMAEn(r_en[0]), .DMAWrEn(r_wr[0]), .DMAAddr(r_addr[0]), .DMAData(r_data[0]),
        .DMAOut(dma_out), .DMAValid(dma_valid),
        .CPUEn(r_en[1]), .CPUWrEn(r_wr[1]), .CPUAddr(r_addr[1]), .CPUData(r_data[1]),
        .CPUOut(cpu_out), .CPUValid(cpu_valid),
        .AclEn(r_en[2]), .AclWrEn(r_wr[2]), .AclAddr(r_addr[2]), .AclData(r_data[2]),
        .AclOut(acl_out), .AclValid(acl_valid),
        .mem_en(m1_en), .mem_wr_en(m1_wr), .mem_addr(m1_addr),
        .mem_wdata(m1_wdata), .mem_rdata(m1_rdata),
        .grant(grant), .busy(busy)
    );

    // Words never written read back as a pattern derived from the address.
    function automatic logic [31:0] init_word(logic [17:0] a);
        return {a[13:0] ^ 14'h1555, a};
    endfunction

    // Memory behind the main DUT: data appears one cycle after mem_en.
    logic [31:0] mem [logic [17:0]];
    always @(posedge clk) begin
        if (m1_en) begin
            if (m1_wr) mem[m1_addr] = m1_wdata;
            else m1_rdata <= mem.exists(m1_addr) ? mem[m1_addr] : init_word(m1_addr);
        end
    end

    // ---------------- second DUT (RD_LATENCY = 3) ----------------
    logic        b_acl_en = 1'b0, b_acl_wr = 1'b0;
    logic [17:0] b_acl_addr = '0;
    logic [31:0] b_dma_out, b_cpu_out, b_acl_out;
    logic        b_dma_valid, b_cpu_valid, b_acl_valid;
    logic        m2_en, m2_wr;
    logic [17:0] m2_addr;
    logic [31:0] m2_wdata;
    logic [31:0] p0, p1, p2;
    logic [2:0]  b_grant;
    logic        b_busy;

    mem_arbiter #(.DATA_WIDTH(32), .ADDR_WIDTH(18), .RD_LATENCY(L2)) u_l3 (
        .clk(clk), .rst_n(rst_n),
        .DMAEn(1'b0), .DMAWrEn(1'b0), .DMAAddr(18'h0), .DMAData(32'h0),
        .DMAOut(b_dma_out), .DMAValid(b_dma_valid),
        .CPUEn(1'b0), .CPUWrEn(1'b0), .CPUAddr(18'h0), .CPUData(32'h0),
        .CPUOut(b_cpu_out), .CPUValid(b_cpu_valid),
        .AclEn(b_acl_en), .AclWrEn(b_acl_wr), .AclAddr(b_acl_addr), .AclData(32'h0),
        .AclOut(b_acl_out), .AclValid(b_acl_valid),
        .mem_en(m2_en), .mem_wr_en(m2_wr), .mem_addr(m2_addr),
        .mem_wdata(m2_wdata), .mem_rdata(p2),
        .grant(b_grant), .busy(b_busy)
    );

    // Three-stage read pipeline: data appears three cycles after mem_en.
    always @(posedge clk) begin
        p0 <= (m2_en && !m2_wr) ? init_word(m2_addr) : 32'h0;
        p1 <= p0;
        p2 <= p1;
    end

    // ---------------- reference model ----------------
    // Transaction level: when the arbiter is free and someone requests, the
    // winner is the first requester after the previous winner; a write
    // completes 2 cycles after the decision, a read 2+RD_LATENCY cycles after.
    logic [31:0] ref_mem [logic [17:0]];
    bit          m_active;
    int          m_win, m_last, m_issue, m_valid, m_free, m_txn;
    logic        m_wr;
    logic [17:0] m_addr;
    logic [31:0] m_data, m_rdata;
    logic [31:0] exp_out [3];
    logic [2:0]  done_v;
    int          obs_cnt [3];
    int          grant_log [$];

    function automatic logic [31:0] ref_rd(logic [17:0] a);
        return ref_mem.exists(a) ? ref_mem[a] : init_word(a);
    endfunction

    task automatic chk(string tag, logic [63:0] obs, logic [63:0] exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else begin
            n_fail++;
            $error("[TB] FAIL %s: observed %0h expected %0h (cycle %0d)", tag, obs, exp, cyc);
        end
    endtask

    task automatic model_reset();
        m_active = 1'b0;
        m_last   = 2;
        m_free   = 0;
        for (int i = 0; i < 3; i++) exp_out[i] = 32'h0;
    endtask

    task automatic chk_zero(string tag);
        chk({tag, "_valid"}, vld, 0);
        chk({tag, "_grant"}, grant, 0);
        chk({tag, "_busy"}, busy, 0);
        chk({tag, "_mem_en"}, m1_en, 0);
        chk({tag, "_dma_out"}, dma_out, 0);
        chk({tag, "_cpu_out"}, cpu_out, 0);
        chk({tag, "_acl_out"}, acl_out, 0);
    endtask

    task automatic model_check();
        logic [2:0] ev, eg;
        bit eb, eme;
        int c;
        c = cyc;
        done_v = 3'b000;
        if (!rst_n) begin
            chk_zero("in_reset");
            model_reset();
            return;
        end
        ev = 0; eg = 0; eb = 0; eme = 0;
        if (m_active) begin
            if (c >= m_issue && c <= m_valid) begin
                eb = 1'b1;
                eg = 3'(1 << m_win);
            end
            eme = (c == m_issue);
            if (c == m_valid) begin
                ev = eg;
                done_v = eg;
                if (!m_wr) exp_out[m_win] = m_rdata;
                else ref_mem[m_addr] = m_data;
            end
        end
        chk("valid", vld, ev);
        chk("grant", grant, eg);
        chk("busy", busy, eb);
        chk("mem_en", m1_en, eme);
        if (eme) begin
            chk("mem_wr_en", m1_wr, m_wr);
            chk("mem_addr", m1_addr, m_addr);
            if (m_wr) chk("mem_wdata", m1_wdata, m_data);
            grant_log.push_back(int'(grant));
        end
        chk("dma_out", dma_out, exp_out[0]);
        chk("cpu_out", cpu_out, exp_out[1]);
        chk("acl_out", acl_out, exp_out[2]);
        for (int i = 0; i < 3; i++) if (vld[i]) obs_cnt[i]++;

        if (m_active && c == m_valid) begin
            m_active = 1'b0;
            m_txn++;
            m_free = c + 1;
        end
        if (!m_active && c >= m_free && (r_en[0] || r_en[1] || r_en[2])) begin
            for (int k = 1; k <= 3; k++) begin
                int idx;
                idx = (m_last + k) % 3;
                if (r_en[idx] && !m_active) begin
                    m_active = 1'b1;
                    m_win    = idx;
                    m_last   = idx;
                    m_wr     = r_wr[idx];
                    m_addr   = r_addr[idx];
                    m_data   = r_data[idx];
                    m_rdata  = ref_rd(r_addr[idx]);
                    m_issue  = c + 1;
                    m_valid  = c + 2 + (r_wr[idx] ? 0 : L1);
                end
            end
        end
    endtask

    // Requester behaviour for the next cycle: drop En right after Valid unless
    // the requester is doing back-to-back requests; random requesters may
    // start a new request once their En has been low for a cycle.
    task automatic plan_next();
        for (int i = 0; i < 3; i++) begin
            if (done_v[i] && !r_keep[i]) begin
                nxt_en[i] = 1'b0;
            end else if (r_auto[i] && !r_en[i] && $urandom_range(0, 2) == 0) begin
                nxt_en[i]   = 1'b1;
                nxt_wr[i]   = 1'($urandom_range(0, 1));
                nxt_addr[i] = ($urandom_range(0, 7) == 0) ? 18'h3FFFF : 18'($urandom_range(0, 7));
                nxt_data[i] = $urandom;
            end
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
        rst_n = nxt_rst;
        for (int i = 0; i < 3; i++) begin
            r_en[i]   = nxt_en[i];
            r_wr[i]   = nxt_wr[i];
            r_addr[i] = nxt_addr[i];
            r_data[i] = nxt_data[i];
        end
        cyc++;
        @(negedge clk);
        model_check();
        plan_next();
    endtask

    task automatic do_reset();
        nxt_rst = 1'b0;
        step();
        step();
        nxt_rst = 1'b1;
    endtask

    task automatic set_req(int i, logic wr, logic [17:0] a, logic [31:0] d, bit keep);
        nxt_en[i]   = 1'b1;
        nxt_wr[i]   = wr;
        nxt_addr[i] = a;
        nxt_data[i] = d;
        r_keep[i]   = keep;
    endtask

    task automatic quiesce(string tag);
        int n;
        n = 0;
        for (int i = 0; i < 3; i++) begin
            r_keep[i] = 0;
            r_auto[i] = 0;
        end
        do begin
            step();
            n++;
        end while ((m_active || r_en[0] || r_en[1] || r_en[2] ||
                    nxt_en[0] || nxt_en[1] || nxt_en[2]) && n < 200);
        chk({tag, "_drain_bound"}, n < 200, 1);
    endtask

    task automatic run_txns(string tag, int count);
        int base, n;
        base = m_txn;
        n = 0;
        while (m_txn < base + count && n < 120) begin
            step();
            n++;
        end
        chk({tag, "_txn_bound"}, n < 120, 1);
    endtask

    task automatic chk_log(string tag, int e0, int e1, int e2, int e3, int e4, int e5, int len);
        int e [6];
        int g;
        e = '{e0, e1, e2, e3, e4, e5};
        for (int i = 0; i < len; i++) begin
            g = (i < grant_log.size()) ? grant_log[i] : -1;
            chk($sformatf("%s_grant%0d", tag, i), g, e[i]);
        end
    endtask

    initial begin
        int n;
        for (int i = 0; i < 3; i++) begin
            r_en[i] = 0; r_wr[i] = 0; r_addr[i] = 0; r_data[i] = 0;
            nxt_en[i] = 0; nxt_wr[i] = 0; nxt_addr[i] = 0; nxt_data[i] = 0;
            r_keep[i] = 0; r_auto[i] = 0; obs_cnt[i] = 0;
        end
        m_txn = 0;
        model_reset();

        // RD_LATENCY=3 instance: Acl reads the top word of the address space.
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        b_acl_en = 1'b1; b_acl_wr = 1'b0; b_acl_addr = 18'h3FFFF;
        for (int k = 0; k < 8; k++) begin
            @(negedge clk);
            chk("l3_mem_en", b_mem_en_w(), k == 1);
            if (k == 1) begin
                chk("l3_mem_addr", m2_addr, 18'h3FFFF);
                chk("l3_mem_wr_en", m2_wr, 0);
            end
            chk("l3_acl_valid", b_acl_valid, k == 5);
            chk("l3_other_valid", {b_cpu_valid, b_dma_valid}, 0);
            chk("l3_busy", b_busy, k >= 1 && k <= 5);
            chk("l3_grant", b_grant, (k >= 1 && k <= 5) ? 3'b100 : 3'b000);
            if (k == 5) chk("l3_acl_out", b_acl_out, {14'h2AAA, 18'h3FFFF});
            @(posedge clk);
            #1;
            if (k == 5) b_acl_en = 1'b0;
        end

        // Reset state of the main instance.
        do_reset();

        // DMA write 0xDEADBEEF to 0x10, then CPU reads it back.
        set_req(0, 1'b1, 18'h00010, 32'hDEADBEEF, 0);
        quiesce("dma_wr");
        set_req(1, 1'b0, 18'h00010, 32'h0, 0);
        quiesce("cpu_rd");
        chk("cpu_readback", cpu_out, 32'hDEADBEEF);

        // All three requesting back-to-back from reset: strict rotation.
        do_reset();
        set_req(0, 1'b1, 18'h00100, 32'h11111111, 1);
        set_req(1, 1'b0, 18'h00010, 32'h0, 1);
        set_req(2, 1'b1, 18'h00101, 32'h22222222, 1);
        grant_log.delete();
        for (int i = 0; i < 3; i++) obs_cnt[i] = 0;
        run_txns("rr6", 6);
        for (int i = 0; i < 3; i++) nxt_en[i] = 0;
        quiesce("rr6");
        chk_log("rr6", 1, 2, 4, 1, 2, 4, 6);
        chk("rr6_dma_pulses", obs_cnt[0], 2);
        chk("rr6_cpu_pulses", obs_cnt[1], 2);
        chk("rr6_acl_pulses", obs_cnt[2], 2);

        // CPU never drops En while Acl also requests: they must alternate.
        set_req(1, 1'b0, 18'h00101, 32'h0, 1);
        set_req(2, 1'b1, 18'h00102, 32'h33333333, 1);
        grant_log.delete();
        run_txns("alt", 3);
        nxt_en[1] = 0;
        nxt_en[2] = 0;
        quiesce("alt");
        chk_log("alt", 2, 4, 2, 0, 0, 0, 3);

        // Reset during the WAIT cycle of a CPU read.
        set_req(1, 1'b0, 18'h00010, 32'h0, 0);
        n = 0;
        do begin
            step();
            n++;
        end while (!(m_active && m_win == 1 && cyc == m_issue + 1) && n < 20);
        chk("wait_reach_bound", n < 20, 1);
        nxt_rst = 1'b0;
        rst_n = 1'b0;
        #1;
        chk_zero("async_rst");
        step();
        step();
        nxt_rst = 1'b1;
        set_req(0, 1'b1, 18'h00020, 32'hCAFEF00D, 0);
        grant_log.delete();
        quiesce("post_rst");
        chk_log("post_rst", 1, 2, 0, 0, 0, 0, 2);

        // Randomised traffic from all three requesters.
        for (int i = 0; i < 3; i++) r_auto[i] = 1;
        repeat (600) step();
        quiesce("random");

        $display("[TB] %0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

    function automatic logic b_mem_en_w();
        return m2_en;
    endfunction

endmodule
